// File: rtl/vm_pkg.sv
// Shared types and constants for the dispense scheduler: FSM state encoding,
// coin weights, one-hot coin encodings and default product prices.
package vm_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DISPENSE = 3'd1,
        CHANGE   = 3'd2,
        GAP      = 3'd3,
        DONE     = 3'd4
    } state_e;

    localparam int COIN_W1 = 1;
    localparam int COIN_W2 = 2;
    localparam int COIN_W5 = 5;

    localparam logic [2:0] COIN_OH_1 = 3'b001;
    localparam logic [2:0] COIN_OH_2 = 3'b010;
    localparam logic [2:0] COIN_OH_5 = 3'b100;

    localparam int DEF_PRICE1 = 3;
    localparam int DEF_PRICE2 = 4;
    localparam int DEF_PRICE3 = 6;

endpackage

// File: rtl/change_coin_sel.sv
// Greedy change selector: picks the largest coin (5, 2, 1) not exceeding the
// remaining credit. Outputs zero when credit is zero.
module change_coin_sel
    import vm_pkg::*;
#(
    parameter int CREDIT_W = 4
) (
    input  logic [CREDIT_W-1:0] credit_i,
    output logic [2:0]          coin_o,
    output logic [CREDIT_W-1:0] value_o
);

    // largest coin that still fits in the remaining credit
    always_comb begin
        coin_o  = '0;
        value_o = '0;
        if (credit_i >= CREDIT_W'(COIN_W5)) begin
            coin_o  = COIN_OH_5;
            value_o = CREDIT_W'(COIN_W5);
        end else if (credit_i >= CREDIT_W'(COIN_W2)) begin
            coin_o  = COIN_OH_2;
            value_o = CREDIT_W'(COIN_W2);
        end else if (credit_i != '0) begin
            coin_o  = COIN_OH_1;
            value_o = CREDIT_W'(COIN_W1);
        end
    end

endmodule

// File: rtl/dispense_scheduler.sv
// Vending dispense scheduler: credit accumulation, product arbitration,
// timed motor drive, coin-by-coin change return and delivery pulse.
// Optional macro VM_RR_ARB_EN selects round-robin arbitration among
// affordable simultaneous requests; otherwise product 1 > 2 > 3.
module dispense_scheduler
    import vm_pkg::*;
#(
    parameter int CREDIT_W    = 4,
    parameter int MAX_CREDIT  = 15,
    parameter int PRICE1      = DEF_PRICE1,
    parameter int PRICE2      = DEF_PRICE2,
    parameter int PRICE3      = DEF_PRICE3,
    parameter int DISP_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [2:0]          req_i,
    input  logic [2:0]          coin_in_i,
    output logic                motor_o,
    output logic [2:0]          product_sel_o,
    output logic                coin_reject_o,
    output logic [2:0]          deny_o,
    output logic [2:0]          coin_out_o,
    output logic                delivered_o,
    output logic                busy_o,
    output logic [CREDIT_W-1:0] credit_o
);

    localparam int CNT_W = $clog2(DISP_CYCLES + 1);
    localparam logic [2:0][CREDIT_W-1:0] PRICES =
        {CREDIT_W'(PRICE3), CREDIT_W'(PRICE2), CREDIT_W'(PRICE1)};

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [2:0]          psel_q, psel_d;
    logic [2:0]          deny_q, deny_d;
    logic                rej_q, rej_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [2:0]          afford, grant;
    logic [CREDIT_W-1:0] gprice;
    logic [CREDIT_W:0]   coin_val, coin_sum;
    logic [2:0]          chg_coin;
    logic [CREDIT_W-1:0] chg_val;

    change_coin_sel #(.CREDIT_W(CREDIT_W)) u_chg (
        .credit_i (credit_q),
        .coin_o   (chg_coin),
        .value_o  (chg_val)
    );

    // requests are priced against the registered credit only
    always_comb begin
        afford = '0;
        for (int i = 0; i < 3; i++)
            afford[i] = req_i[i] && (credit_q >= PRICES[i]);
    end

`ifdef VM_RR_ARB_EN
    logic [1:0] ptr_q, ptr_d, gnext, j;

    // search starts at the product after the last one granted
    always_comb begin
        grant = '0;
        gnext = ptr_q;
        j     = '0;
        for (int k = 0; k < 3; k++) begin
            j = 2'((int'(ptr_q) + k) % 3);
            if (grant == '0 && afford[j]) begin
                grant[j] = 1'b1;
                gnext    = (j == 2'd2) ? 2'd0 : j + 2'd1;
            end
        end
    end

    // round-robin pointer register
    always_ff @(posedge clk) begin
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end
`else
    // fixed priority: lowest product number wins
    always_comb begin
        grant    = '0;
        grant[0] = afford[0];
        grant[1] = afford[1] & ~afford[0];
        grant[2] = afford[2] & ~(|afford[1:0]);
    end
`endif

    // price of the granted product and value of the inserted coin
    always_comb begin
        gprice = '0;
        for (int i = 0; i < 3; i++)
            if (grant[i]) gprice = PRICES[i];
        case (coin_in_i)
            COIN_OH_1: coin_val = (CREDIT_W+1)'(COIN_W1);
            COIN_OH_2: coin_val = (CREDIT_W+1)'(COIN_W2);
            COIN_OH_5: coin_val = (CREDIT_W+1)'(COIN_W5);
            default:   coin_val = '0;
        endcase
        coin_sum = {1'b0, credit_q} + coin_val;
    end

    // next-state, credit bookkeeping and registered pulse generation
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        psel_d   = psel_q;
        cnt_d    = cnt_q;
        deny_d   = '0;
        rej_d    = (coin_in_i != '0) && (state_q != IDLE);
`ifdef VM_RR_ARB_EN
        ptr_d    = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                deny_d = req_i & ~afford;
                if (grant != '0) begin
                    credit_d = credit_q - gprice;
                    psel_d   = grant;
                    cnt_d    = CNT_W'(DISP_CYCLES - 1);
                    state_d  = DISPENSE;
                    rej_d    = (coin_in_i != '0);
`ifdef VM_RR_ARB_EN
                    ptr_d    = gnext;
`endif
                end else if (coin_in_i != '0) begin
                    if (!$onehot(coin_in_i) || coin_sum > (CREDIT_W+1)'(MAX_CREDIT))
                        rej_d = 1'b1;
                    else
                        credit_d = coin_sum[CREDIT_W-1:0];
                end
            end
            DISPENSE: begin
                if (cnt_q == '0)
                    state_d = (credit_q != '0) ? CHANGE : DONE;
                else
                    cnt_d = cnt_q - 1'b1;
            end
            CHANGE: begin
                credit_d = credit_q - chg_val;
                state_d  = (credit_q == chg_val) ? DONE : GAP;
            end
            GAP: state_d = CHANGE;
            DONE: begin
                psel_d  = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers; reset abandons any transaction in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            credit_q <= '0;
            psel_q   <= '0;
            deny_q   <= '0;
            rej_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            psel_q   <= psel_d;
            deny_q   <= deny_d;
            rej_q    <= rej_d;
            cnt_q    <= cnt_d;
        end
    end

    assign motor_o       = (state_q == DISPENSE);
    assign coin_out_o    = (state_q == CHANGE) ? chg_coin : 3'b000;
    assign delivered_o   = (state_q == DONE);
    assign busy_o        = (state_q != IDLE);
    assign product_sel_o = psel_q;
    assign deny_o        = deny_q;
    assign coin_reject_o = rej_q;
    assign credit_o      = credit_q;

endmodule
